ccff_chain_loader: RTL
======================

Name: ccff_chain_loader

Overview:
- Drives the head of the routing configuration chain.
- Takes decrypted bitstream words on a valid/ready stream and serializes them MSB-first onto ccff_head, one bit per shift cycle, with a per-bit shift enable.
- Checks stream length against the chain length and monitors ccff_tail for integrity.
- Sits between the bitstream decryption/FIFO stage and the first switch/connection block's ccff_head.

Parameters:
- WORD_W, 32, bitstream word width in bits.
- CHAIN_LEN, 4096, total configuration flops in the chain this loader feeds.
- CNT_W, $clog2(CHAIN_LEN+1), bit counter width.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load.
- bs_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- bs_valid  input  1  word valid.
- bs_last  input  1  marks final word of the stream; qualified by bs_valid.
- bs_ready  output  1  loader accepts a word.
- ccff_head  output  1  serial config data into the chain.
- ccff_shift_en  output  1  chain captures ccff_head on this prog_clk edge.
- ccff_tail  input  1  serial output of the chain's last flop.
- busy  output  1  load in progress.
- done  output  1  load completed cleanly; sticky.
- err  output  1  load aborted; sticky.
- err_code  output  2  1=underrun, 2=overrun, 3=tail nonzero.
- bit_count  output  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (pReset low, async): FSM=IDLE; bs_ready, ccff_head, ccff_shift_en, busy, done, err = 0; err_code=0; bit_count=0; shift register=0. Reset mid-load abandons the load with no partial-state retention.
- IDLE:
  - Outputs quiescent.
  - start -> LOAD; clear done, err, err_code, bit_count.
- LOAD:
  - busy=1, bs_ready=1, ccff_shift_en=0.
  - On bs_valid&bs_ready: capture bs_data into sreg, bs_last into word_last, bits_left=WORD_W; -> SHIFT.
  - No timeout while waiting.
- SHIFT:
  - busy=1, bs_ready=0, ccff_shift_en=1, ccff_head=sreg[WORD_W-1] (combinational from sreg).
  - Each cycle: sreg<<=1, bits_left--, bit_count++.
  - Throughput is WORD_W bits per WORD_W+1 cycles (one LOAD bubble per word).
- SHIFT exit conditions, evaluated on the incremented values and in this priority:
  - ccff_tail==1 sampled while ccff_shift_en=1 -> ERROR, code 3. Chain was reset to 0, so its tail must read 0 for the first CHAIN_LEN shifts.
  - bit_count==CHAIN_LEN: word_last=1 -> DONE; else -> ERROR, code 2. Unshifted LSBs of the last word are padding and are discarded.
  - bits_left==0 and word_last=1 (bit_count<CHAIN_LEN) -> ERROR, code 1.
  - bits_left==0, otherwise -> LOAD.
- DONE: busy=0, done=1 held.
- ERROR: busy=0, err=1, err_code held. ccff_shift_en drops the cycle after detection; no further bits reach the chain.
- start in DONE/ERROR -> LOAD with flags cleared. start while busy is ignored.
- bit_count saturates at CHAIN_LEN.
- ccff_head=0 whenever ccff_shift_en=0.

Test Plan (WORD_W=8, CHAIN_LEN=20):
- Clean load: start; words 0xA5, 0x3C, 0xF0 (last) -> exactly 20 shift_en cycles; ccff_head sequence 10100101 00111100 1111; done=1, err=0, bit_count=20; 0xF0's low nibble never driven.
- Underrun: start; 0xFF, 0x01 (last) -> 16 shifts, then err=1, err_code=1, bit_count=16, shift_en low next cycle.
- Overrun: start; 0x11, 0x22, 0x33 (no last) -> after 20th shift err=1, err_code=2, bs_ready stays 0.
- Tail fault: force ccff_tail=1 during the 5th shift -> err_code=3, bit_count=5, no 6th shift.
- Backpressure: bs_valid low 7 cycles between words -> shift_en low throughout gap, head bit order unchanged, done at 20.
- Reset mid-load: pReset low at shift 9 -> all outputs 0 immediately; after release, start with the clean-load stream -> done=1.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Drives the head of the routing configuration chain. Bitstream words
// arrive on a valid/ready stream and are shifted MSB-first onto ccff_head,
// one bit per prog_clk cycle while ccff_shift_en is high. The loader
// checks the stream length against CHAIN_LEN and watches ccff_tail: the
// chain starts at all-zero, so any 1 seen on the tail during the first
// CHAIN_LEN shifts means the chain is broken.
//
// Ports:
//   prog_clk       programming clock, all state on rising edge
//   pReset         asynchronous active-low reset
//   start          one-cycle pulse, begins a load (ignored while busy)
//   bs_data        bitstream word, bit WORD_W-1 shifted first
//   bs_valid       word valid
//   bs_last        final word of the stream, qualified by bs_valid
//   bs_ready       loader accepts a word
//   ccff_head      serial config data into the chain
//   ccff_shift_en  chain captures ccff_head on this edge
//   ccff_tail      serial output of the chain's last flop
//   busy           load in progress
//   done           load completed cleanly (sticky)
//   err            load aborted (sticky)
//   err_code       1=underrun, 2=overrun, 3=tail nonzero
//   bit_count      bits shifted so far in the current load
module ccff_chain_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 4096,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   input  logic              bs_last,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  bit_count
);

   localparam int                BL_W      = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0]  CHAIN_END = CNT_W'(CHAIN_LEN);
   localparam logic [BL_W-1:0]   WORD_BITS = BL_W'(WORD_W);

   localparam logic [1:0] CODE_UNDERRUN = 2'd1;
   localparam logic [1:0] CODE_OVERRUN  = 2'd2;
   localparam logic [1:0] CODE_TAIL     = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t              state, state_nxt;
   logic [WORD_W-1:0]   sreg, sreg_nxt;
   logic                word_last, word_last_nxt;
   logic [BL_W-1:0]     bits_left, bits_left_nxt;
   logic [CNT_W-1:0]    bit_count_nxt;
   logic                done_nxt, err_nxt;
   logic [1:0]          err_code_nxt;
   logic [CNT_W-1:0]    cnt_inc;
   logic [BL_W-1:0]     bl_dec;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CHAIN_END) return v;
      return v + 1'b1;
   endfunction

   // Outputs are decoded from state so reset forces them low at once.
   assign busy          = (state == S_LOAD) || (state == S_SHIFT);
   assign bs_ready      = (state == S_LOAD);
   assign ccff_shift_en = (state == S_SHIFT);
   assign ccff_head     = (state == S_SHIFT) && sreg[WORD_W-1];

   always_comb begin
      state_nxt     = state;
      sreg_nxt      = sreg;
      word_last_nxt = word_last;
      bits_left_nxt = bits_left;
      bit_count_nxt = bit_count;
      done_nxt      = done;
      err_nxt       = err;
      err_code_nxt  = err_code;
      cnt_inc       = sat_inc(bit_count);
      bl_dec        = bits_left - 1'b1;

      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_nxt     = S_LOAD;
               done_nxt      = 1'b0;
               err_nxt       = 1'b0;
               err_code_nxt  = 2'd0;
               bit_count_nxt = '0;
            end
         end
         S_LOAD: begin
            if (bs_valid) begin
               sreg_nxt      = bs_data;
               word_last_nxt = bs_last;
               bits_left_nxt = WORD_BITS;
               state_nxt     = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sreg_nxt      = {sreg[WORD_W-2:0], 1'b0};
            bits_left_nxt = bl_dec;
            bit_count_nxt = cnt_inc;
            // Exit checks use the post-shift counts; tail fault wins.
            if (ccff_tail) begin
               state_nxt    = S_ERROR;
               err_nxt      = 1'b1;
               err_code_nxt = CODE_TAIL;
            end else if (cnt_inc == CHAIN_END) begin
               // Chain full: remaining LSBs of the last word are padding.
               if (word_last) begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt    = S_ERROR;
                  err_nxt      = 1'b1;
                  err_code_nxt = CODE_OVERRUN;
               end
            end else if (bl_dec == '0) begin
               if (word_last) begin
                  state_nxt    = S_ERROR;
                  err_nxt      = 1'b1;
                  err_code_nxt = CODE_UNDERRUN;
               end else begin
                  state_nxt = S_LOAD;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state     <= S_IDLE;
         sreg      <= '0;
         word_last <= 1'b0;
         bits_left <= '0;
         bit_count <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         word_last <= word_last_nxt;
         bits_left <= bits_left_nxt;
         bit_count <= bit_count_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         err_code  <= err_code_nxt;
      end
   end

endmodule
